// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: signal bundle between the VC pop scheduler and its surroundings.
//
// Signals:
//   init       control -> arbiter   synchronous request to enter/hold INIT
//   vc0_empty  fifo    -> arbiter   VC0 FIFO empty flag
//   vc1_empty  fifo    -> arbiter   VC1 FIFO empty flag
//   pause      sink    -> arbiter   downstream almost-full, blocks all pops
//   pop_vc0    arbiter -> fifo/mux  combinational pop for VC0 (pop_delay_vc0)
//   pop_vc1    arbiter -> fifo/mux  combinational pop for VC1 (pop_delay_vc1)
//   valid_out  arbiter -> demux     registered, mux output holds popped data
//   vc_sel_d   arbiter -> demux     registered channel tag of mux output data
//   state      arbiter -> status    registered FSM state
//   idle       arbiter -> status    IDLE with both FIFOs empty
//
// Modports: master = the arbiter, slave = the environment around it.
interface vc_arbiter_if;
    logic       init;
    logic       vc0_empty;
    logic       vc1_empty;
    logic       pause;
    logic       pop_vc0;
    logic       pop_vc1;
    logic       valid_out;
    logic       vc_sel_d;
    logic [1:0] state;
    logic       idle;

    modport master (
        input  init, vc0_empty, vc1_empty, pause,
        output pop_vc0, pop_vc1, valid_out, vc_sel_d, state, idle
    );

    modport slave (
        output init, vc0_empty, vc1_empty, pause,
        input  pop_vc0, pop_vc1, valid_out, vc_sel_d, state, idle
    );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter: pop scheduler for the two-virtual-channel output stage.
//
// Watches the VC0/VC1 FIFO empty flags and downstream pause, and drives at most one
// pop per cycle. valid_out/vc_sel_d are registered so they line up with the registered
// VC mux output.
//
// Ports:
//   clk      single clock, rising edge
//   reset_L  asynchronous active-low reset
//   bus      vc_arbiter_if.master (init, empties, pause in; pops, tags, state, idle out)
//
// Parameters:
//   WEIGHT   max consecutive VC0 pops while VC1 waits (fairness build only), 1..2^CNT_W-1
//   CNT_W    width of the VC0 streak counter
//
// Optional feature: define VC_ARB_FAIR_EN to force a VC1 pop after WEIGHT consecutive
// VC0 pops under contention. Undefined gives strict VC0 priority and no streak counter.
module vc_arbiter #(
    parameter int unsigned WEIGHT = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic          clk,
    input  logic          reset_L,
    vc_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        StReset  = 2'b00,
        StInit   = 2'b01,
        StIdle   = 2'b10,
        StActive = 2'b11
    } state_e;

    if ((WEIGHT < 1) || (WEIGHT > (2 ** CNT_W) - 1)) begin : g_bad_weight
        $error("vc_arbiter: WEIGHT out of range for CNT_W");
    end

    state_e state_q, state_d;
    logic   valid_q, valid_d;
    logic   tag_q, tag_d;
    logic   pop0, pop1;
    logic   any_data;

    assign any_data = !bus.vc0_empty || !bus.vc1_empty;

`ifdef VC_ARB_FAIR_EN
    localparam logic [CNT_W-1:0] WeightC = CNT_W'(WEIGHT);

    logic [CNT_W-1:0] streak_q, streak_d;
    logic             starve;

    // VC0 has used up its burst allowance and VC1 is waiting.
    assign starve = (streak_q == WeightC) && !bus.vc1_empty;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.init && (state_q != StReset)) begin
            state_d = StInit;
        end else begin
            unique case (state_q)
                StReset:  state_d = StInit;
                StInit:   if (!bus.init) state_d = StIdle;
                StIdle:   if (any_data && !bus.pause) state_d = StActive;
                StActive: if (!any_data || bus.pause) state_d = StIdle;
                default:  state_d = StReset;
            endcase
        end
    end

    // Output logic: pops are purely combinational so pause and reset kill them at once.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if ((state_q == StActive) && !bus.pause) begin
`ifdef VC_ARB_FAIR_EN
            if (!bus.vc0_empty && !starve) begin
                pop0 = 1'b1;
            end else if (!bus.vc1_empty) begin
                pop1 = 1'b1;
            end
`else
            if (!bus.vc0_empty) begin
                pop0 = 1'b1;
            end else if (!bus.vc1_empty) begin
                pop1 = 1'b1;
            end
`endif
        end
    end

    // Tag pipeline: the tag holds its last channel when nothing is popped.
    always_comb begin
        valid_d = pop0 || pop1;
        tag_d   = (pop0 || pop1) ? pop1 : tag_q;
    end

`ifdef VC_ARB_FAIR_EN
    always_comb begin
        streak_d = streak_q;
        if ((state_q != StActive) || pop1 || bus.vc1_empty) begin
            streak_d = '0;
        end else if (pop0 && (streak_q != WeightC)) begin
            streak_d = streak_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_q  <= 1'b0;
            tag_q    <= 1'b0;
`ifdef VC_ARB_FAIR_EN
            streak_q <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
`ifdef VC_ARB_FAIR_EN
            streak_q <= streak_d;
`endif
        end
    end

    assign bus.pop_vc0   = pop0;
    assign bus.pop_vc1   = pop1;
    assign bus.valid_out = valid_q;
    assign bus.vc_sel_d  = tag_q;
    assign bus.state     = state_q;
    assign bus.idle      = (state_q == StIdle) && bus.vc0_empty && bus.vc1_empty;

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed self-checking bench for vc_arbiter (WEIGHT=4, CNT_W=3).
// The bench keeps per-channel word counts and derives the empty flags from them.
module tb_vc_arbiter;

    localparam logic [1:0] SReset  = 2'b00;
    localparam logic [1:0] SInit   = 2'b01;
    localparam logic [1:0] SIdle   = 2'b10;
    localparam logic [1:0] SActive = 2'b11;

`ifdef VC_ARB_FAIR_EN
    // bit i set = cycle i pops VC1, else VC0
    localparam bit [7:0] PatBoth  = 8'b1001_0000;
    localparam bit [7:0] PatReset = 8'b1101_0000;
`else
    localparam bit [7:0] PatBoth  = 8'b1100_0000;
    localparam bit [7:0] PatReset = 8'b1110_0000;
`endif

    logic clk = 1'b0;
    logic reset_L;
    int   total = 0;
    int   bad   = 0;
    int   cnt0  = 0;
    int   cnt1  = 0;

    always #5 clk = ~clk;

    vc_arbiter_if bus ();

    vc_arbiter #(
        .WEIGHT (4),
        .CNT_W  (3)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: present empties from the word counts, check pops, clock, check tags.
    task automatic cyc(input logic e0, input logic e1, input string tag);
        bus.vc0_empty = (cnt0 == 0);
        bus.vc1_empty = (cnt1 == 0);
        #1;
        check_eq({tag, "_pop0"}, bus.pop_vc0, e0);
        check_eq({tag, "_pop1"}, bus.pop_vc1, e1);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, bus.valid_out, e0 | e1);
        if (e0 | e1) check_eq({tag, "_sel"}, bus.vc_sel_d, e1);
        if (e0) cnt0--;
        if (e1) cnt1--;
    endtask

    task automatic run_pattern(input bit [7:0] pat, input string tag);
        for (int i = 0; i < 8; i++) begin
            cyc(!pat[i], pat[i], tag);
        end
    endtask

    // Safety properties checked every cycle away from the active edge.
    always @(negedge clk) begin
        check_eq("excl", bus.pop_vc0 & bus.pop_vc1, 0);
        check_eq("pop0_on_empty", bus.pop_vc0 & bus.vc0_empty, 0);
        check_eq("pop1_on_empty", bus.pop_vc1 & bus.vc1_empty, 0);
    end

    initial begin
        reset_L       = 1'b0;
        bus.init      = 1'b0;
        bus.pause     = 1'b0;
        bus.vc0_empty = 1'b1;
        bus.vc1_empty = 1'b1;
        #2;
        check_eq("rst_state", bus.state, SReset);
        check_eq("rst_pop0", bus.pop_vc0, 0);
        check_eq("rst_pop1", bus.pop_vc1, 0);
        check_eq("rst_valid", bus.valid_out, 0);
        check_eq("rst_sel", bus.vc_sel_d, 0);
        check_eq("rst_idle", bus.idle, 0);

        // Release with init held, then drop init
        bus.init = 1'b1;
        #5 reset_L = 1'b1;
        @(posedge clk); #1;
        check_eq("init_enter", bus.state, SInit);
        @(posedge clk); #1;
        check_eq("init_hold", bus.state, SInit);
        bus.init = 1'b0;
        @(posedge clk); #1;
        check_eq("init_exit", bus.state, SIdle);
        check_eq("idle_empty", bus.idle, 1);

        // VC1 only, three words
        cnt1 = 3;
        bus.vc1_empty = 1'b0;
        #1 check_eq("idle_busy", bus.idle, 0);
        cyc(0, 0, "v1_wake");
        check_eq("v1_active", bus.state, SActive);
        for (int i = 0; i < 3; i++) cyc(0, 1, "v1_pop");
        cyc(0, 0, "v1_drain");
        check_eq("v1_idle", bus.state, SIdle);
        check_eq("v1_idle_flag", bus.idle, 1);

        // Contention
        cnt0 = 6;
        cnt1 = 2;
        cyc(0, 0, "both_wake");
        run_pattern(PatBoth, "both");
        cyc(0, 0, "both_drain");
        check_eq("both_idle", bus.state, SIdle);

        // Pause mid-burst
        cnt0 = 4;
        cyc(0, 0, "pz_wake");
        cyc(1, 0, "pz_pre");
        cyc(1, 0, "pz_pre");
        bus.pause = 1'b1;
        cyc(0, 0, "pz_kill");
        check_eq("pz_state", bus.state, SIdle);
        cyc(0, 0, "pz_hold");
        check_eq("pz_hold_state", bus.state, SIdle);
        bus.pause = 1'b0;
        cyc(0, 0, "pz_resume");
        check_eq("pz_resume_state", bus.state, SActive);
        cyc(1, 0, "pz_post");
        cyc(1, 0, "pz_post");
        cyc(0, 0, "pz_drain");
        check_eq("pz_end_state", bus.state, SIdle);
        check_eq("pz_words_left", cnt0[7:0], 0);

        // Asynchronous reset during ACTIVE
        cnt0 = 8;
        cnt1 = 3;
        cyc(0, 0, "ar_wake");
        for (int i = 0; i < 3; i++) cyc(1, 0, "ar_pre");
        #1 reset_L = 1'b0;
        #1;
        check_eq("ar_pop0", bus.pop_vc0, 0);
        check_eq("ar_pop1", bus.pop_vc1, 0);
        check_eq("ar_valid", bus.valid_out, 0);
        check_eq("ar_state", bus.state, SReset);
        #1 reset_L = 1'b1;
        bus.vc0_empty = (cnt0 == 0);
        bus.vc1_empty = (cnt1 == 0);
        @(posedge clk); #1;
        check_eq("ar_init", bus.state, SInit);
        @(posedge clk); #1;
        check_eq("ar_idle", bus.state, SIdle);
        cyc(0, 0, "ar_rewake");
        run_pattern(PatReset, "ar_run");
        cyc(0, 0, "ar_drain");
        check_eq("ar_end_state", bus.state, SIdle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
